// File: rtl/exec_ctrl.sv
// Register-file execution controller that sequences one ALU operation per instruction
// (IDLE -> EXEC -> WB). Optional status flags are built when EXEC_CTRL_FLAGS_EN is defined.
module exec_ctrl #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  localparam int SW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opr,
  input  logic [SW-1:0] in_dst,
  input  logic [SW-1:0] in_src,
  input  logic [DW-1:0] in_imm,
  input  logic          in_imm_en,
  input  logic          ld_en,
  input  logic [SW-1:0] ld_sel,
  input  logic [DW-1:0] ld_data,
  input  logic [SW-1:0] rd_sel,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] a_data_bus,
  output logic [DW-1:0] b_data_bus,
  output logic [2:0]    opr,
  output logic          en,
  output logic [DW-1:0] direct_data_bus,
  output logic          direct_data_bus_en,
  input  logic [DW-1:0] out_data_bus,
  output logic          done,
  output logic          flag_z,
  output logic          flag_lt,
  output logic          flag_dz
);

  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] res_q, res_d;

  // Latched instruction fields; only meaningful while EXEC/WB, so no reset needed.
  logic [2:0]    opr_q;
  logic [SW-1:0] dst_q, src_q;
  logic [DW-1:0] imm_q;
  logic          imm_en_q;

  logic          accept;
  logic [DW-1:0] a_val, b_reg, b_eff;
  logic          is_cmp, div_zero, wr_en;

  assign accept   = in_valid && (state_q == S_IDLE);
  assign a_val    = regs_q[dst_q];
  assign b_reg    = regs_q[src_q];
  assign b_eff    = imm_en_q ? imm_q : b_reg;
  assign is_cmp   = (opr_q == OP_CMP);
  assign div_zero = (opr_q == OP_DIV) && (b_eff == '0);
  assign wr_en    = !is_cmp && !div_zero;
  assign rd_data  = regs_q[rd_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opr_q    <= in_opr;
      dst_q    <= in_dst;
      src_q    <= in_src;
      imm_q    <= in_imm;
      imm_en_q <= in_imm_en;
    end
  end

  always_comb begin
    state_d            = state_q;
    res_d              = res_q;
    in_ready           = 1'b0;
    done               = 1'b0;
    en                 = 1'b0;
    a_data_bus         = '0;
    b_data_bus         = '0;
    opr                = '0;
    direct_data_bus    = '0;
    direct_data_bus_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        a_data_bus         = a_val;
        b_data_bus         = b_reg;
        opr                = opr_q;
        direct_data_bus    = imm_q;
        direct_data_bus_en = imm_en_q;
        en                 = !is_cmp && !div_zero;
        res_d              = out_data_bus;
        state_d            = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Direct loads and writeback live in different states, so they never collide.
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (ld_en && (state_q == S_IDLE)) regs_d[ld_sel] = ld_data;
    if ((state_q == S_WB) && wr_en) regs_d[dst_q] = res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef EXEC_CTRL_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_lt_q, flag_lt_d;
  logic flag_dz_q, flag_dz_d;

  // Registers are frozen between EXEC and WB, so compare operands are still valid here.
  always_comb begin
    flag_z_d  = flag_z_q;
    flag_lt_d = flag_lt_q;
    flag_dz_d = flag_dz_q;
    if (state_q == S_WB) begin
      flag_z_d  = is_cmp ? (a_val == b_eff) : (res_q == '0);
      flag_lt_d = is_cmp && (a_val < b_eff);
      flag_dz_d = div_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q  <= 1'b0;
      flag_lt_q <= 1'b0;
      flag_dz_q <= 1'b0;
    end else begin
      flag_z_q  <= flag_z_d;
      flag_lt_q <= flag_lt_d;
      flag_dz_q <= flag_dz_d;
    end
  end

  assign flag_z  = flag_z_q;
  assign flag_lt = flag_lt_q;
  assign flag_dz = flag_dz_q;
`else
  assign flag_z  = 1'b0;
  assign flag_lt = 1'b0;
  assign flag_dz = 1'b0;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomized bench for exec_ctrl: a bench-side ALU answers the DUT, and an array-based
// reference model of the register file predicts every result, bus value and flag.
module tb_exec_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_imm_en;
  logic [2:0]    in_opr;
  logic [1:0]    in_dst, in_src;
  logic [DW-1:0] in_imm;
  logic          ld_en;
  logic [1:0]    ld_sel, rd_sel;
  logic [DW-1:0] ld_data, rd_data;
  logic [DW-1:0] a_data_bus, b_data_bus, direct_data_bus, out_data_bus;
  logic [2:0]    opr;
  logic          en, direct_data_bus_en, done, flag_z, flag_lt, flag_dz;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] mreg [4];
  logic          ef_z, ef_lt, ef_dz;

  exec_ctrl #(.DW(DW), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opr(in_opr), .in_dst(in_dst), .in_src(in_src), .in_imm(in_imm), .in_imm_en(in_imm_en),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .a_data_bus(a_data_bus), .b_data_bus(b_data_bus), .opr(opr), .en(en),
    .direct_data_bus(direct_data_bus), .direct_data_bus_en(direct_data_bus_en),
    .out_data_bus(out_data_bus),
    .done(done), .flag_z(flag_z), .flag_lt(flag_lt), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned ai, bi, r;
    ai = a;
    bi = b;
    case (op)
      3'd0: r = ai + bi;
      3'd1: r = ai - bi;
      3'd2: r = ai * bi;
      3'd3: r = (bi == 0) ? 0 : ai / bi;
      3'd4: r = ai & bi;
      3'd5: r = ai | bi;
      3'd6: r = ai ^ bi;
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  // Stand-in ALU: idle (drives 0) whenever the controller does not enable it.
  assign out_data_bus = en ? alu(opr, a_data_bus, direct_data_bus_en ? direct_data_bus : b_data_bus) : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag);
`ifdef EXEC_CTRL_FLAGS_EN
    chk({tag, "_fz"}, flag_z, ef_z);
    chk({tag, "_flt"}, flag_lt, ef_lt);
    chk({tag, "_fdz"}, flag_dz, ef_dz);
`else
    chk({tag, "_flags"}, {flag_z, flag_lt, flag_dz}, 3'b000);
`endif
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [DW-1:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mreg[sel] = data;
    rd_sel = sel;
    #1 chk("load_rd", rd_data, data);
    chk_flags("load_hold");
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                           input logic [DW-1:0] imm, input logic imm_en,
                           input logic co_ld, input logic [1:0] co_sel, input logic [DW-1:0] co_data,
                           input logic late_ld);
    logic [DW-1:0] a, b, res;
    logic dz, wr;
    rd_sel = dst;
    in_valid = 1'b1; in_opr = op; in_dst = dst; in_src = src; in_imm = imm; in_imm_en = imm_en;
    if (co_ld) begin
      ld_en = 1'b1; ld_sel = co_sel; ld_data = co_data;
      mreg[co_sel] = co_data;
    end
    chk("idle_ready", in_ready, 1'b1);
    a   = mreg[dst];
    b   = imm_en ? imm : mreg[src];
    dz  = (op == 3'd3) && (b == 0);
    wr  = (op != 3'd7) && !dz;
    res = wr ? alu(op, a, b) : '0;
    @(posedge clk); #1;
    in_valid = 1'b0; ld_en = 1'b0;
    chk("exec_ready", in_ready, 1'b0);
    chk("exec_done", done, 1'b0);
    chk("exec_en", en, wr);
    chk("exec_a", a_data_bus, a);
    chk("exec_b", b_data_bus, mreg[src]);
    chk("exec_opr", opr, op);
    chk("exec_dbus", direct_data_bus, imm);
    chk("exec_dbus_en", direct_data_bus_en, imm_en);
    if (late_ld) begin
      ld_en = 1'b1; ld_sel = 2'($urandom); ld_data = DW'($urandom);
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
    chk("wb_done", done, 1'b1);
    chk("wb_en", en, 1'b0);
    chk("wb_ready", in_ready, 1'b0);
    chk("wb_a", a_data_bus, '0);
    if (wr) mreg[dst] = res;
    if (op == 3'd7) begin
      ef_z = (a == b); ef_lt = (a < b); ef_dz = 1'b0;
    end else begin
      ef_z = (res == 0); ef_lt = 1'b0; ef_dz = dz;
    end
    @(posedge clk); #1;
    chk("post_done", done, 1'b0);
    chk("post_ready", in_ready, 1'b1);
    chk("post_rd", rd_data, mreg[dst]);
    chk_flags("post");
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1 chk(tag, rd_data, mreg[i]);
    end
  endtask

  initial begin
    int acc, dones;
    rst_n = 1'b0; in_valid = 1'b0; in_opr = '0; in_dst = '0; in_src = '0; in_imm = '0;
    in_imm_en = 1'b0; ld_en = 1'b0; ld_sel = '0; ld_data = '0; rd_sel = '0;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    ef_z = 1'b0; ef_lt = 1'b0; ef_dz = 1'b0;
    #3;
    chk("rst_done", done, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_abus", a_data_bus, '0);
    sweep("rst_reg");
    chk_flags("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("rel_ready", in_ready, 1'b1);

    // ADD r0 = 5 + 3
    do_load(2'd0, 8'h05); do_load(2'd1, 8'h03);
    run_instr(3'd0, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("add_r0", rd_data, 8'h08);
    // SUB with immediate reaching zero
    do_load(2'd2, 8'hF0);
    run_instr(3'd1, 2'd2, 2'd0, 8'hF0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("sub_r2", rd_data, 8'h00);
    // Divide by zero: no write
    do_load(2'd0, 8'h10);
    run_instr(3'd3, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("dz_r0", rd_data, 8'h10);
    // CMP 2 vs 9: no write, less-than
    do_load(2'd1, 8'h02); do_load(2'd3, 8'h09);
    run_instr(3'd7, 2'd1, 2'd3, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("cmp_r1", rd_data, 8'h02);
    // Load coinciding with accept feeds the instruction
    run_instr(3'd2, 2'd2, 2'd3, 8'h00, 1'b0, 1'b1, 2'd2, 8'h07, 1'b1);
    chk("coload_mul", rd_data, 8'h3F);

    // Back-to-back: in_valid held high
    in_valid = 1'b1; in_opr = 3'd0; in_dst = 2'd0; in_src = 2'd1; in_imm_en = 1'b0; rd_sel = 2'd0;
    acc = 0; dones = 0;
    for (int c = 0; c < 9; c++) begin
      chk("b2b_ready", in_ready, (c % 3) == 0);
      chk("b2b_done", done, (c % 3) == 2);
      if (in_ready) acc++;
      if (done) dones++;
      if (c == 8) in_valid = 1'b0;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    chk("b2b_acc", acc, 3);
    chk("b2b_dones", dones, 3);
    mreg[0] = mreg[0] + 3 * mreg[1];
    ef_z = (mreg[0] == 0); ef_lt = 1'b0; ef_dz = 1'b0;
    chk("b2b_r0", rd_data, mreg[0]);
    chk_flags("b2b");

    // Randomized instructions with random direct loads around them
    for (int it = 0; it < 60; it++) begin
      logic [DW-1:0] imm;
      if ($urandom_range(0, 2) == 0) do_load(2'($urandom), DW'($urandom));
      imm = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
      run_instr(3'($urandom), 2'($urandom), 2'($urandom), imm, 1'($urandom),
                ($urandom_range(0, 3) == 0), 2'($urandom), DW'($urandom), 1'($urandom));
    end
    sweep("rand_sweep");

    // Reset during EXEC of MUL aborts it
    do_load(2'd0, 8'h20); do_load(2'd1, 8'h10);
    in_valid = 1'b1; in_opr = 3'd2; in_dst = 2'd0; in_src = 2'd1; in_imm_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_exec_en", en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", en, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_abus", a_data_bus, '0);
    chk("abort_opr", opr, 3'd0);
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    ef_z = 1'b0; ef_lt = 1'b0; ef_dz = 1'b0;
    sweep("abort_reg");
    chk_flags("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("abort_ready", in_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_nodone", done, 1'b0);
    end
    sweep("abort_final");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
